iomem_gpio_ctrl: RTL

IOMEM_GPIO_CTRL -- requirements
Module: iomem_gpio_ctrl

---
 rtl/iomem_gpio_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/iomem_gpio_ctrl.sv
// GPIO block on the picorv32-style iomem bus: OUT/DIR/IN plus SET/CLR/TOG, edge interrupts under IOMEM_GPIO_IRQ_EN.
// One-cycle registered ack per request, never stalls; foreign BASE_BYTE requests are left unanswered.
module iomem_gpio_ctrl #(
   parameter int         WIDTH     = 8,
   parameter logic [7:0] BASE_BYTE = 8'h03
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             iomem_valid,
   output logic             iomem_ready,
   input  logic [3:0]       iomem_wstrb,
   input  logic [31:0]      iomem_addr,
   input  logic [31:0]      iomem_wdata,
   output logic [31:0]      iomem_rdata,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   localparam logic [5:0] OFF_OUT  = 6'd0;
   localparam logic [5:0] OFF_DIR  = 6'd1;
   localparam logic [5:0] OFF_IN   = 6'd2;
   localparam logic [5:0] OFF_SET  = 6'd3;
   localparam logic [5:0] OFF_CLR  = 6'd4;
   localparam logic [5:0] OFF_TOG  = 6'd5;
   localparam logic [5:0] OFF_IEN  = 6'd6;
   localparam logic [5:0] OFF_RISE = 6'd7;
   localparam logic [5:0] OFF_STAT = 6'd8;

   logic             sel;
   logic             wr;
   logic [5:0]       off;
   logic [31:0]      bmask;
   logic [31:0]      wm32;
   logic [WIDTH-1:0] bmask_w;
   logic [WIDTH-1:0] wm_w;
   logic [31:0]      rd_val;
   logic             unused_bits;

   logic [WIDTH-1:0] out_r;
   logic [WIDTH-1:0] dir_r;
   logic [WIDTH-1:0] sync1_r;
   logic [WIDTH-1:0] in_r;

   // !iomem_ready keeps a still-high valid from being acked twice
   assign sel     = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_BYTE);
   assign wr      = |iomem_wstrb;
   assign off     = iomem_addr[7:2];
   assign bmask   = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                     {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
   assign wm32    = iomem_wdata & bmask;
   assign bmask_w = bmask[WIDTH-1:0];
   assign wm_w    = wm32[WIDTH-1:0];

   assign unused_bits = ^{iomem_addr[23:8], iomem_addr[1:0], bmask, wm32};

   assign gpio_out = out_r;
   assign gpio_oe  = dir_r;

`ifdef IOMEM_GPIO_IRQ_EN
   logic [WIDTH-1:0] ien_r;
   logic [WIDTH-1:0] rise_r;
   logic [WIDTH-1:0] stat_r;
   logic [WIDTH-1:0] prev_r;
   logic [WIDTH-1:0] edge_w;
   logic [WIDTH-1:0] w1c;

   assign edge_w = (rise_r & in_r & ~prev_r) | (~rise_r & ~in_r & prev_r);
   assign w1c    = (sel && wr && off == OFF_STAT) ? wm_w : '0;

   // edge ORed after the clear so a coincident edge survives a W1C
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ien_r  <= '0;
         rise_r <= '0;
         stat_r <= '0;
         prev_r <= '0;
         irq    <= 1'b0;
      end else begin
         prev_r <= in_r;
         stat_r <= (stat_r & ~w1c) | edge_w;
         irq    <= |(stat_r & ien_r);
         if (sel && wr) begin
            case (off)
               OFF_IEN:  ien_r  <= (ien_r & ~bmask_w) | wm_w;
               OFF_RISE: rise_r <= (rise_r & ~bmask_w) | wm_w;
               default: ;
            endcase
         end
      end
   end
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rd_val = '0;
      case (off)
         OFF_OUT:  rd_val[WIDTH-1:0] = out_r;
         OFF_DIR:  rd_val[WIDTH-1:0] = dir_r;
         OFF_IN:   rd_val[WIDTH-1:0] = in_r;
`ifdef IOMEM_GPIO_IRQ_EN
         OFF_IEN:  rd_val[WIDTH-1:0] = ien_r;
         OFF_RISE: rd_val[WIDTH-1:0] = rise_r;
         OFF_STAT: rd_val[WIDTH-1:0] = stat_r;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         out_r       <= '0;
         dir_r       <= '0;
         sync1_r     <= '0;
         in_r        <= '0;
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
      end else begin
         sync1_r     <= gpio_in;
         in_r        <= sync1_r;
         iomem_ready <= sel;
         if (sel) begin
            iomem_rdata <= rd_val;
         end
         if (sel && wr) begin
            case (off)
               OFF_OUT: out_r <= (out_r & ~bmask_w) | wm_w;
               OFF_DIR: dir_r <= (dir_r & ~bmask_w) | wm_w;
               OFF_SET: out_r <= out_r | wm_w;
               OFF_CLR: out_r <= out_r & ~wm_w;
               OFF_TOG: out_r <= out_r ^ wm_w;
               default: ;
            endcase
         end
      end
   end

endmodule
